// File: rtl/lcd_sync_rx_if.sv
// LCD sync stream (HD/VD/DEN/RGB, error clear) and receiver status outputs.
// The stream source is the master; lcd_sync_rx is the slave.
interface lcd_sync_rx_if;
    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned CW = 8;

    logic          hd;
    logic          vd;
    logic          den;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          err_clr;
    logic          pix_valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3*CW-1:0] pix_rgb;
    logic          frame_done;
    logic [XW-1:0] h_meas;
    logic [YW-1:0] v_meas;
    logic [3:0]    err;
    logic          locked;
    logic          bar_err;

    modport master (
        output hd, vd, den, r, g, b, err_clr,
        input  pix_valid, x, y, pix_rgb, frame_done, h_meas, v_meas, err, locked, bar_err
    );

    modport slave (
        input  hd, vd, den, r, g, b, err_clr,
        output pix_valid, x, y, pix_rgb, frame_done, h_meas, v_meas, err, locked, bar_err
    );
endinterface

// File: rtl/lcd_sync_rx.sv
// LCD sync stream receiver: pixel coordinate recovery, line/frame timing check and lock.
// Optional colour-bar checker enabled by defining BAR_CHECK_EN.
module lcd_sync_rx #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_TOTAL     = 1056,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    lcd_sync_rx_if.slave bus
);
    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;
    localparam int unsigned GW = 8;
    localparam int unsigned RGBW = 24;
    localparam logic [HW-1:0] HMAX = '1;
    localparam logic [VW-1:0] VMAX = '1;

    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

    state_t state;
    state_t state_next;

    logic            hd_q, vd_q, den_q, clr_q, hd_qq, vd_qq;
    logic [RGBW-1:0] rgb_q;

    // Single input register plus a second sync stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_q  <= 1'b0;
            vd_q  <= 1'b0;
            den_q <= 1'b0;
            clr_q <= 1'b0;
            rgb_q <= '0;
            hd_qq <= 1'b0;
            vd_qq <= 1'b0;
        end else begin
            hd_q  <= bus.hd;
            vd_q  <= bus.vd;
            den_q <= bus.den;
            clr_q <= bus.err_clr;
            rgb_q <= {bus.r, bus.g, bus.b};
            hd_qq <= hd_q;
            vd_qq <= vd_q;
        end
    end

    logic hd_fall, vd_fall, chk;
    assign hd_fall = hd_qq & ~hd_q;
    assign vd_fall = vd_qq & ~vd_q;
    assign chk     = (state != SEARCH);

    logic [HW-1:0] hcnt, xcnt, xbase, hlen;
    logic [VW-1:0] vcnt, ycnt, vcnt_l, ycnt_l;
    logic [GW-1:0] good, good_next;
    logic [3:0]    new_err;
    logic          frame_bad, bar_new, any_err, frame_done_c;

    // Line end is accounted before frame end; ycnt doubles as the active-line count
    always_comb begin
        hlen    = (hcnt == HMAX) ? HMAX : hcnt + HW'(1);
        xbase   = xcnt;
        vcnt_l  = vcnt;
        ycnt_l  = ycnt;
        new_err = '0;
        if (hd_fall) begin
            xbase = '0;
            if (vcnt != VMAX) vcnt_l = vcnt + VW'(1);
            if ((xcnt != '0) && (ycnt != VMAX)) ycnt_l = ycnt + VW'(1);
            if (chk) begin
                new_err[0] = (hlen != HW'(H_TOTAL));
                new_err[1] = (xcnt != '0) && (xcnt != HW'(H_ACTIVE));
            end
        end
        if (vd_fall) begin
            if (chk) begin
                new_err[3] = (vcnt_l != VW'(V_TOTAL));
                new_err[2] = (ycnt_l != VW'(V_ACTIVE));
            end
            ycnt_l = '0;
        end
    end

`ifdef BAR_CHECK_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [HW-1:0]   bar_pos, pos_base;
    logic [3:0]      bar_idx, idx_base;
    logic [RGBW-1:0] bar_rgb;
    logic            bar_err;

    // Bar index bit pattern maps directly to white/yellow/cyan/green/magenta/red/blue/black
    always_comb begin
        pos_base = hd_fall ? '0 : bar_pos;
        idx_base = hd_fall ? '0 : bar_idx;
        bar_rgb  = {{8{~idx_base[1]}}, {8{~idx_base[2]}}, {8{~idx_base[0]}}};
        bar_new  = chk && den_q && !idx_base[3] && (rgb_q != bar_rgb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_pos <= '0;
            bar_idx <= '0;
            bar_err <= 1'b0;
        end else begin
            bar_err <= (clr_q ? 1'b0 : bar_err) | bar_new;
            if (den_q) begin
                if (pos_base == HW'(BAR_W - 1)) begin
                    bar_pos <= '0;
                    bar_idx <= idx_base[3] ? idx_base : idx_base + 4'd1;
                end else begin
                    bar_pos <= pos_base + HW'(1);
                    bar_idx <= idx_base;
                end
            end else begin
                bar_pos <= pos_base;
                bar_idx <= idx_base;
            end
        end
    end

    assign bus.bar_err = bar_err;
`else
    assign bar_new     = 1'b0;
    assign bus.bar_err = 1'b0;
`endif

    assign any_err = (new_err != '0) || bar_new;

    // Lock FSM: next state, good-frame counter and frame pulse
    always_comb begin
        state_next   = state;
        good_next    = good;
        frame_done_c = 1'b0;
        case (state)
            SEARCH: begin
                if (vd_fall) begin
                    state_next = MEASURE;
                    good_next  = '0;
                end
            end
            MEASURE: begin
                if (vd_fall) begin
                    frame_done_c = 1'b1;
                    if (frame_bad || any_err) begin
                        good_next = '0;
                    end else begin
                        good_next = good + GW'(1);
                        if (good_next == GW'(LOCK_FRAMES)) state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                frame_done_c = vd_fall;
                if (any_err) begin
                    state_next = SEARCH;
                    good_next  = '0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    logic            pix_valid, frame_done, locked;
    logic [HW-1:0]   x, h_meas;
    logic [VW-1:0]   y, v_meas;
    logic [RGBW-1:0] pix_rgb;
    logic [3:0]      err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            good       <= '0;
            frame_bad  <= 1'b0;
            hcnt       <= '0;
            xcnt       <= '0;
            vcnt       <= '0;
            ycnt       <= '0;
            pix_valid  <= 1'b0;
            x          <= '0;
            y          <= '0;
            pix_rgb    <= '0;
            frame_done <= 1'b0;
            h_meas     <= '0;
            v_meas     <= '0;
            err        <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_next;
            good       <= good_next;
            frame_bad  <= vd_fall ? 1'b0 : (frame_bad | any_err);
            hcnt       <= hd_fall ? '0 : hlen;
            xcnt       <= (den_q && (xbase != HMAX)) ? xbase + HW'(1) : xbase;
            vcnt       <= vd_fall ? '0 : vcnt_l;
            ycnt       <= ycnt_l;
            pix_valid  <= den_q;
            frame_done <= frame_done_c;
            err        <= (clr_q ? 4'd0 : err) | new_err;
            locked     <= (state_next == LOCKED);
            if (hd_fall) h_meas <= hlen;
            if (vd_fall) v_meas <= vcnt_l;
            if (den_q) begin
                x       <= xbase;
                y       <= ycnt_l;
                pix_rgb <= rgb_q;
            end
        end
    end

    assign bus.pix_valid  = pix_valid;
    assign bus.x          = x;
    assign bus.y          = y;
    assign bus.pix_rgb    = pix_rgb;
    assign bus.frame_done = frame_done;
    assign bus.h_meas     = h_meas;
    assign bus.v_meas     = v_meas;
    assign bus.err        = err;
    assign bus.locked     = locked;
endmodule
